// File: rtl/risc_execute_pkg.sv
// Shared opcode encodings, default widths and MUL sequencer states for the execute stage.
package risc_execute_pkg;

  localparam int RISC_DATA_W   = 8;
  localparam int RISC_ADDR_W   = 4;
  localparam int RISC_MUL_ITER = 8;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_MOV = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_CMP = 4'h8,
    OP_MUL = 4'h9
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/risc_execute_if.sv
// Issue, regfile read and writeback signals of the execute stage bundled together.
interface risc_execute_if #(
  parameter int DATA_W = risc_execute_pkg::RISC_DATA_W,
  parameter int ADDR_W = risc_execute_pkg::RISC_ADDR_W
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [ADDR_W-1:0] in_rd_addr;
  logic [ADDR_W-1:0] in_rs1_addr;
  logic [ADDR_W-1:0] in_rs2_addr;
  logic [DATA_W-1:0] in_imm;
  logic              in_use_imm;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs1;
  logic [DATA_W-1:0] rs2;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd;
  logic              rd_write;
  logic              flag_z;
  logic              flag_c;

  modport master (
    output in_valid, in_op, in_rd_addr, in_rs1_addr, in_rs2_addr, in_imm, in_use_imm,
    output rs1, rs2,
    input  in_ready, rs1_addr, rs2_addr, rd_addr, rd, rd_write, flag_z, flag_c
  );

  modport slave (
    input  in_valid, in_op, in_rd_addr, in_rs1_addr, in_rs2_addr, in_imm, in_use_imm,
    input  rs1, rs2,
    output in_ready, rs1_addr, rs2_addr, rd_addr, rd, rd_write, flag_z, flag_c
  );
endinterface

// File: rtl/risc_execute_alu.sv
// Combinational single-cycle ALU; MUL and unknown opcodes come out as no-write, no-flag.
module risc_execute_alu
  import risc_execute_pkg::*;
#(
  parameter int DATA_W = RISC_DATA_W
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              z,
  output logic              c,
  output logic              we,
  output logic              flag_en
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    // The extra top bit of the difference is the unsigned borrow (a < b).
    diff    = {1'b0, a} - {1'b0, b};
    result  = '0;
    c       = 1'b0;
    we      = 1'b0;
    flag_en = 1'b0;
    case (op)
      OP_ADD: begin result = sum[DATA_W-1:0];  c = sum[DATA_W];  we = 1'b1; flag_en = 1'b1; end
      OP_SUB: begin result = diff[DATA_W-1:0]; c = diff[DATA_W]; we = 1'b1; flag_en = 1'b1; end
      OP_CMP: begin result = diff[DATA_W-1:0]; c = diff[DATA_W];            flag_en = 1'b1; end
      OP_AND: begin result = a & b; we = 1'b1; flag_en = 1'b1; end
      OP_OR:  begin result = a | b; we = 1'b1; flag_en = 1'b1; end
      OP_XOR: begin result = a ^ b; we = 1'b1; flag_en = 1'b1; end
      OP_MOV: begin result = b;     we = 1'b1; end
      OP_SHL: begin result = {a[DATA_W-2:0], 1'b0}; c = a[DATA_W-1]; we = 1'b1; flag_en = 1'b1; end
      OP_SHR: begin result = {1'b0, a[DATA_W-1:1]}; c = a[0];        we = 1'b1; flag_en = 1'b1; end
      default: ;
    endcase
    z = (result == '0);
  end
endmodule

// File: rtl/risc_execute.sv
// Execute/writeback stage: one issue register (S1), W/P result bypass and a shift-add MUL sequencer.
module risc_execute
  import risc_execute_pkg::*;
#(
  parameter int DATA_W   = RISC_DATA_W,
  parameter int ADDR_W   = RISC_ADDR_W,
  parameter int MUL_ITER = RISC_MUL_ITER
) (
  input logic          clk,
  input logic          rst_n,
  risc_execute_if.slave bus
);
  localparam int              CNT_W    = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

  op_t               op_p1;
  logic              vld_p1;
  logic [ADDR_W-1:0] rd_addr_p1, rs1_addr_p1, rs2_addr_p1;
  logic [DATA_W-1:0] imm_p1;
  logic              use_imm_p1;

  logic              vld_p3;
  logic [ADDR_W-1:0] addr_p3;
  logic [DATA_W-1:0] data_p3;

  mul_state_t          state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc, mcand, acc_step;
  logic [DATA_W-1:0]   mplier;

  logic              ready, accept, is_mul, mul_start, mul_done;
  logic [DATA_W-1:0] op_a, op_b_reg, op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_c, alu_we, alu_flag_en;

  assign bus.rs1_addr = bus.in_rs1_addr;
  assign bus.rs2_addr = bus.in_rs2_addr;
  assign bus.in_ready = ready;
  assign accept       = bus.in_valid & ready;
  assign is_mul       = vld_p1 && (op_p1 == OP_MUL);

  // W (current writeback) has priority over P (the result the regfile is writing as S1 reads it).
  always_comb begin
    op_a     = bus.rs1;
    op_b_reg = bus.rs2;
    if (bus.rd_write && bus.rd_addr == rs1_addr_p1)  op_a = bus.rd;
    else if (vld_p3 && addr_p3 == rs1_addr_p1)        op_a = data_p3;
    if (bus.rd_write && bus.rd_addr == rs2_addr_p1)  op_b_reg = bus.rd;
    else if (vld_p3 && addr_p3 == rs2_addr_p1)        op_b_reg = data_p3;
    op_b = use_imm_p1 ? imm_p1 : op_b_reg;
  end

  assign acc_step = mplier[0] ? acc + mcand : acc;

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready     = !is_mul;
        mul_start = is_mul;
        if (mul_start) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        mul_done = (cnt == CNT_LAST);
        if (mul_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  risc_execute_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (op_p1),
    .a       (op_a),
    .b       (op_b),
    .result  (alu_res),
    .z       (alu_z),
    .c       (alu_c),
    .we      (alu_we),
    .flag_en (alu_flag_en)
  );

  // ---- S1 -> W/P boundary: control, writeback and bypass registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      vld_p1       <= 1'b0;
      bus.rd_write <= 1'b0;
      bus.rd       <= '0;
      bus.rd_addr  <= '0;
      bus.flag_z   <= 1'b0;
      bus.flag_c   <= 1'b0;
      vld_p3       <= 1'b0;
      addr_p3      <= '0;
      data_p3      <= '0;
    end else begin
      state        <= state_nxt;
      vld_p3       <= bus.rd_write;
      addr_p3      <= bus.rd_addr;
      data_p3      <= bus.rd;
      bus.rd_write <= 1'b0;
      if (mul_done) begin
        vld_p1       <= 1'b0;
        bus.rd_write <= 1'b1;
        bus.rd       <= acc_step[DATA_W-1:0];
        bus.rd_addr  <= rd_addr_p1;
        bus.flag_z   <= (acc_step[DATA_W-1:0] == '0);
        bus.flag_c   <= (acc_step[2*DATA_W-1:DATA_W] != '0);
      end else begin
        if (ready) vld_p1 <= accept;
        if (vld_p1 && !is_mul) begin
          if (alu_we) begin
            bus.rd_write <= 1'b1;
            bus.rd       <= alu_res;
            bus.rd_addr  <= rd_addr_p1;
          end
          if (alu_flag_en) begin
            bus.flag_z <= alu_z;
            bus.flag_c <= alu_c;
          end
        end
      end
    end
  end

  // ---- Issue -> S1 boundary and MUL datapath ----
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1       <= op_t'(bus.in_op);
      rd_addr_p1  <= bus.in_rd_addr;
      rs1_addr_p1 <= bus.in_rs1_addr;
      rs2_addr_p1 <= bus.in_rs2_addr;
      imm_p1      <= bus.in_imm;
      use_imm_p1  <= bus.in_use_imm;
    end
    if (mul_start) begin
      acc    <= '0;
      mcand  <= {{DATA_W{1'b0}}, op_a};
      mplier <= op_b;
      cnt    <= '0;
    end else if (state == ST_BUSY) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_risc_execute.sv
// Closed-loop bench: risc_execute driving a behavioural 16x8 regfile with registered reads.
module tb_risc_execute
  import risc_execute_pkg::*;
;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   hist0, hist1;

  risc_execute_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  risc_execute #(.DATA_W(8), .ADDR_W(4), .MUL_ITER(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile: reads registered on every edge, a write lands at the same edge (read sees old data).
  logic [7:0] regs [16];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      bus.rs1 <= '0;
      bus.rs2 <= '0;
    end else begin
      bus.rs1 <= regs[bus.rs1_addr];
      bus.rs2 <= regs[bus.rs2_addr];
      if (bus.rd_write) regs[bus.rd_addr] <= bus.rd;
    end
  end

  typedef struct {
    int         gap;
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [7:0] imm;
    logic       ui;
    logic       wr;
    logic [7:0] res;
    logic       z;
    logic       c;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [7:0] imm, input logic ui);
    bus.in_valid    = v;
    bus.in_op       = op;
    bus.in_rd_addr  = rd;
    bus.in_rs1_addr = rs1;
    bus.in_rs2_addr = rs2;
    bus.in_imm      = imm;
    bus.in_use_imm  = ui;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0);
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [7:0] imm, input logic ui);
    @(negedge clk);
    drive(1'b1, op, rd, rs1, rs2, imm, ui);
    @(posedge clk);
  endtask

  task automatic check_vec(input int i);
    chk($sformatf("v%0d_wr", i), 16'(bus.rd_write), 16'(vecs[i].wr));
    if (vecs[i].wr) begin
      chk($sformatf("v%0d_rd", i), 16'(bus.rd), 16'(vecs[i].res));
      chk($sformatf("v%0d_rd_addr", i), 16'(bus.rd_addr), 16'(vecs[i].rd));
    end
    chk($sformatf("v%0d_z", i), 16'(bus.flag_z), 16'(vecs[i].z));
    chk($sformatf("v%0d_c", i), 16'(bus.flag_c), 16'(vecs[i].c));
  endtask

  // One issue slot: results seen now belong to the slot driven two negedges ago.
  task automatic slot(input int idx);
    @(negedge clk);
    if (hist1 >= 0) check_vec(hist1);
    else chk("idle_wr", 16'(bus.rd_write), 16'h0);
    hist1 = hist0;
    hist0 = idx;
    if (idx >= 0)
      drive(1'b1, vecs[idx].op, vecs[idx].rd, vecs[idx].rs1, vecs[idx].rs2, vecs[idx].imm, vecs[idx].ui);
    else
      idle();
  endtask

  task automatic wait_write(input string name, input logic [3:0] addr, input int limit,
                            output logic [7:0] val, output logic z, output logic c);
    logic found;
    found = 1'b0;
    val = '0; z = 1'b0; c = 1'b0;
    for (int k = 0; k < limit && !found; k++) begin
      @(negedge clk);
      if (bus.rd_write && bus.rd_addr == addr) begin
        found = 1'b1;
        val = bus.rd; z = bus.flag_z; c = bus.flag_c;
      end
    end
    chk({name, "_seen"}, 16'(found), 16'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lowcnt, wcyc, r15cnt, wcnt;
    logic [7:0] mul_rd, r15val, v;
    logic       mz, mc, z, c;

    checks = 0; failures = 0; hist0 = -1; hist1 = -1;
    //          gap op     rd     rs1    rs2    imm    ui wr res    z  c
    vecs[0]  = '{0, OP_MOV, 4'd1,  4'd0,  4'd0,  8'h05, 1, 1, 8'h05, 0, 0};
    vecs[1]  = '{0, OP_MOV, 4'd2,  4'd0,  4'd0,  8'h03, 1, 1, 8'h03, 0, 0};
    vecs[2]  = '{0, OP_ADD, 4'd3,  4'd1,  4'd2,  8'h00, 0, 1, 8'h08, 0, 0};
    vecs[3]  = '{0, OP_MOV, 4'd2,  4'd0,  4'd0,  8'h07, 1, 1, 8'h07, 0, 0};
    vecs[4]  = '{1, OP_ADD, 4'd4,  4'd1,  4'd2,  8'h00, 0, 1, 8'h0C, 0, 0};
    vecs[5]  = '{0, OP_MOV, 4'd2,  4'd0,  4'd0,  8'h03, 1, 1, 8'h03, 0, 0};
    vecs[6]  = '{0, OP_MOV, 4'd1,  4'd0,  4'd0,  8'hFF, 1, 1, 8'hFF, 0, 0};
    vecs[7]  = '{0, OP_ADD, 4'd5,  4'd1,  4'd0,  8'h01, 1, 1, 8'h00, 1, 1};
    vecs[8]  = '{0, OP_SUB, 4'd5,  4'd2,  4'd1,  8'h00, 0, 1, 8'h04, 0, 1};
    vecs[9]  = '{0, OP_CMP, 4'd0,  4'd2,  4'd2,  8'h00, 0, 0, 8'h00, 1, 0};
    vecs[10] = '{0, OP_XOR, 4'd7,  4'd1,  4'd2,  8'h00, 0, 1, 8'hFC, 0, 0};
    vecs[11] = '{0, OP_AND, 4'd8,  4'd1,  4'd2,  8'h00, 0, 1, 8'h03, 0, 0};
    vecs[12] = '{0, OP_OR,  4'd9,  4'd3,  4'd4,  8'h00, 0, 1, 8'h0C, 0, 0};
    vecs[13] = '{0, OP_SHL, 4'd10, 4'd1,  4'd0,  8'h00, 0, 1, 8'hFE, 0, 1};
    vecs[14] = '{0, OP_SHR, 4'd11, 4'd2,  4'd0,  8'h00, 0, 1, 8'h01, 0, 1};
    vecs[15] = '{0, 4'hF,   4'd12, 4'd1,  4'd2,  8'h00, 0, 0, 8'h00, 0, 1};
    vecs[16] = '{0, OP_MOV, 4'd13, 4'd0,  4'd7,  8'h00, 0, 1, 8'hFC, 0, 1};
    vecs[17] = '{0, OP_AND, 4'd14, 4'd1,  4'd0,  8'h00, 1, 1, 8'h00, 1, 0};
    vecs[18] = '{0, OP_MOV, 4'd1,  4'd0,  4'd0,  8'h05, 1, 1, 8'h05, 1, 0};

    rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready",   16'(bus.in_ready), 16'h1);
    chk("rst_wr",      16'(bus.rd_write), 16'h0);
    chk("rst_rd",      16'(bus.rd),       16'h0);
    chk("rst_rd_addr", 16'(bus.rd_addr),  16'h0);
    chk("rst_z",       16'(bus.flag_z),   16'h0);
    chk("rst_c",       16'(bus.flag_c),   16'h0);

    for (int i = 0; i < NV; i++) begin
      repeat (vecs[i].gap) slot(-1);
      slot(i);
    end
    slot(-1);
    slot(-1);
    @(posedge clk); #1;
    chk("rf_r0",  16'(regs[0]),  16'h00);
    chk("rf_r1",  16'(regs[1]),  16'h05);
    chk("rf_r2",  16'(regs[2]),  16'h03);
    chk("rf_r3",  16'(regs[3]),  16'h08);
    chk("rf_r4",  16'(regs[4]),  16'h0C);
    chk("rf_r5",  16'(regs[5]),  16'h04);
    chk("rf_r12", 16'(regs[12]), 16'h00);
    chk("rf_r13", 16'(regs[13]), 16'hFC);

    // MUL r6,r1,r2 = 5*3 with the following ADD r15,r6,#0 held valid through the stall.
    issue(OP_MUL, 4'd6, 4'd1, 4'd2, 8'h00, 1'b0);
    #1;
    chk("mul1_ready_t0", 16'(bus.in_ready), 16'h0);
    drive(1'b1, OP_ADD, 4'd15, 4'd6, 4'd0, 8'h00, 1'b1);
    lowcnt = 0; wcyc = 0; r15cnt = 0; r15val = '0; mul_rd = '0; mz = 1'b0; mc = 1'b0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (!bus.in_ready) lowcnt++;
      if (bus.rd_write && bus.rd_addr == 4'd6) begin
        wcyc = cyc; mul_rd = bus.rd; mz = bus.flag_z; mc = bus.flag_c;
      end
      if (bus.rd_write && bus.rd_addr == 4'd15) begin
        r15cnt++; r15val = bus.rd;
      end
      if (cyc == 11) idle();
    end
    chk("mul1_ready_low_cycles", 16'(lowcnt), 16'd9);
    chk("mul1_write_cycle",      16'(wcyc),   16'd10);
    chk("mul1_rd",               16'(mul_rd), 16'h0F);
    chk("mul1_z",                16'(mz),     16'h0);
    chk("mul1_c",                16'(mc),     16'h0);
    chk("mul1_next_accepts",     16'(r15cnt), 16'd1);
    chk("mul1_next_rd",          16'(r15val), 16'h0F);

    // MUL with operands forwarded from W (r2) and P (r1): 0x20*0x10 -> low byte 0, carry set.
    issue(OP_MOV, 4'd1, 4'd0, 4'd0, 8'h20, 1'b1);
    issue(OP_MOV, 4'd2, 4'd0, 4'd0, 8'h10, 1'b1);
    issue(OP_MUL, 4'd6, 4'd1, 4'd2, 8'h00, 1'b0);
    #1 idle();
    wait_write("mul2", 4'd6, 20, v, z, c);
    chk("mul2_rd", 16'(v), 16'h00);
    chk("mul2_z",  16'(z), 16'h1);
    chk("mul2_c",  16'(c), 16'h1);

    // Reset while the sequencer is mid-way (cnt=4) must abort with no writeback.
    issue(OP_MUL, 4'd7, 4'd1, 4'd2, 8'h00, 1'b0);
    #1 idle();
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rst_wr", 16'(bus.rd_write), 16'h0);
    chk("abort_rst_z",  16'(bus.flag_z),   16'h0);
    chk("abort_rst_c",  16'(bus.flag_c),   16'h0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", 16'(bus.in_ready), 16'h1);
    wcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.rd_write) wcnt++;
    end
    chk("abort_no_write", 16'(wcnt),         16'd0);
    chk("abort_z_after",  16'(bus.flag_z),   16'h0);
    chk("abort_c_after",  16'(bus.flag_c),   16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
